// File: rtl/bus_terminal_fifo.sv
// bus_terminal_fifo: per-terminal TX/RX FIFO pair between a device agent and
// one port of the bus generator/arbiter. Both FIFOs are first-word-fall-through
// circular buffers. Status flags are registered, and the RX side filters by
// destination ID.
//
// Handshakes: a transfer happens on a rising edge where the producer's
// request is high and the consumer can take it.
//   TX to bus:     pndng acts as valid and pop as ready. pop is ignored while pndng=0.
//   Bus to RX:     push is a one-cycle strobe. It is stored when the ID matches and there is room.
//   RX to agent:   rx_valid acts as valid and rx_ready as ready. rx_ready is ignored while rx_valid=0.
//   Agent to TX:   wr_en is a one-cycle strobe. It is dropped and counted when the FIFO is full with no same-cycle pop.
module bus_terminal_fifo #(
    parameter int          pckg_sz   = 32,
    parameter int          depth     = 8,
    parameter logic [7:0]  id        = 8'd0,
    parameter logic [7:0]  broadcast = 8'hFF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [pckg_sz-1:0] wr_data,
    output logic               full,
    output logic               pndng,
    output logic [pckg_sz-1:0] D_pop,
    input  logic               pop,
    input  logic               push,
    input  logic [pckg_sz-1:0] D_push,
    output logic               rx_valid,
    output logic [pckg_sz-1:0] rx_data,
    input  logic               rx_ready,
    output logic [15:0]        tx_ovf_cnt,
    output logic [15:0]        rx_drop_cnt
);

    localparam int              PW       = (depth > 1) ? $clog2(depth) : 1;
    localparam int              CW       = $clog2(depth + 1);
    localparam logic [PW-1:0]   LAST_PTR = PW'(depth - 1);
    localparam logic [CW-1:0]   FULL_CNT = CW'(depth);

    // Pointer advance with wrap from depth-1 to 0 (depth need not be 2^n)
    function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // ---------------- TX side ----------------
    logic [pckg_sz-1:0] r_tx_mem [depth];
    logic [PW-1:0]      r_tx_wr_ptr, r_tx_rd_ptr;
    logic [CW-1:0]      r_tx_cnt;
    logic               r_tx_full, r_tx_pndng;
    logic [15:0]        r_tx_ovf;

    logic               w_tx_pop, w_tx_wr, w_tx_ovf;
    logic [CW-1:0]      w_tx_cnt_nxt;

    // TX accept/overflow decisions; a same-cycle pop frees the slot for a write
    always_comb begin
        w_tx_pop     = pop & r_tx_pndng;
        w_tx_wr      = wr_en & (~r_tx_full | w_tx_pop);
        w_tx_ovf     = wr_en & ~w_tx_wr;
        w_tx_cnt_nxt = r_tx_cnt + CW'(w_tx_wr) - CW'(w_tx_pop);
    end

    // TX storage write; contents are not reset, the pointers make them invisible
    always_ff @(posedge clk) begin
        if (!reset && w_tx_wr)
            r_tx_mem[r_tx_wr_ptr] <= wr_data;
    end

    // TX pointers, occupancy, registered flags and saturating overflow count
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_wr_ptr <= '0;
            r_tx_rd_ptr <= '0;
            r_tx_cnt    <= '0;
            r_tx_full   <= 1'b0;
            r_tx_pndng  <= 1'b0;
            r_tx_ovf    <= '0;
        end else begin
            if (w_tx_wr)  r_tx_wr_ptr <= inc_ptr(r_tx_wr_ptr);
            if (w_tx_pop) r_tx_rd_ptr <= inc_ptr(r_tx_rd_ptr);
            r_tx_cnt   <= w_tx_cnt_nxt;
            r_tx_full  <= (w_tx_cnt_nxt == FULL_CNT);
            r_tx_pndng <= (w_tx_cnt_nxt != '0);
            if (w_tx_ovf && r_tx_ovf != 16'hFFFF)
                r_tx_ovf <= r_tx_ovf + 16'd1;
        end
    end

    // ---------------- RX side ----------------
    logic [pckg_sz-1:0] r_rx_mem [depth];
    logic [PW-1:0]      r_rx_wr_ptr, r_rx_rd_ptr;
    logic [CW-1:0]      r_rx_cnt;
    logic               r_rx_full, r_rx_valid;
    logic [15:0]        r_rx_drop;

    logic [7:0]         w_dest;
    logic               w_match, w_rx_pop, w_rx_wr, w_rx_drop;
    logic [CW-1:0]      w_rx_cnt_nxt;

    // RX destination filter and accept/drop decisions
    always_comb begin
        w_dest       = D_push[pckg_sz-1 -: 8];
        w_match      = (w_dest == id) || (w_dest == broadcast);
        w_rx_pop     = rx_ready & r_rx_valid;
        w_rx_wr      = push & w_match & (~r_rx_full | w_rx_pop);
        w_rx_drop    = push & ~w_rx_wr;
        w_rx_cnt_nxt = r_rx_cnt + CW'(w_rx_wr) - CW'(w_rx_pop);
    end

    // RX storage write
    always_ff @(posedge clk) begin
        if (!reset && w_rx_wr)
            r_rx_mem[r_rx_wr_ptr] <= D_push;
    end

    // RX pointers, occupancy, registered valid and saturating drop count
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_wr_ptr <= '0;
            r_rx_rd_ptr <= '0;
            r_rx_cnt    <= '0;
            r_rx_full   <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_rx_drop   <= '0;
        end else begin
            if (w_rx_wr)  r_rx_wr_ptr <= inc_ptr(r_rx_wr_ptr);
            if (w_rx_pop) r_rx_rd_ptr <= inc_ptr(r_rx_rd_ptr);
            r_rx_cnt   <= w_rx_cnt_nxt;
            r_rx_full  <= (w_rx_cnt_nxt == FULL_CNT);
            r_rx_valid <= (w_rx_cnt_nxt != '0);
            if (w_rx_drop && r_rx_drop != 16'hFFFF)
                r_rx_drop <= r_rx_drop + 16'd1;
        end
    end

    // Heads fall through from storage, forced to zero while empty so reset
    // and empty states present a clean value
    assign D_pop       = r_tx_pndng ? r_tx_mem[r_tx_rd_ptr] : '0;
    assign rx_data     = r_rx_valid ? r_rx_mem[r_rx_rd_ptr] : '0;
    assign full        = r_tx_full;
    assign pndng       = r_tx_pndng;
    assign rx_valid    = r_rx_valid;
    assign tx_ovf_cnt  = r_tx_ovf;
    assign rx_drop_cnt = r_rx_drop;

endmodule

// File: tb/tb_bus_terminal_fifo.sv
// Self-checking bench for bus_terminal_fifo (depth=8, id=2). Stimulus pushes
// the expected packets into queues, and monitors pop and compare them on
// every TX pop and RX consume.
module tb_bus_terminal_fifo;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         wr_en = 1'b0;
    logic [W-1:0] wr_data = '0;
    logic         full, pndng, rx_valid;
    logic [W-1:0] D_pop, rx_data;
    logic         pop = 1'b0;
    logic         push = 1'b0;
    logic [W-1:0] D_push = '0;
    logic         rx_ready = 1'b0;
    logic [15:0]  tx_ovf_cnt, rx_drop_cnt;

    logic [W-1:0] tx_exp_q[$];
    logic [W-1:0] rx_exp_q[$];

    int total = 0;
    int bad   = 0;

    bus_terminal_fifo #(.pckg_sz(W), .depth(8), .id(8'd2), .broadcast(8'hFF)) dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_data(wr_data), .full(full),
        .pndng(pndng), .D_pop(D_pop), .pop(pop),
        .push(push), .D_push(D_push),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_ovf_cnt(tx_ovf_cnt), .rx_drop_cnt(rx_drop_cnt)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- check helpers ----------------
    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: act=%h exp=%h", name, act, exp);
        end
    endtask

    // ---------------- monitors / scoreboard ----------------
    // Inputs change #1 after posedge, so at negedge they are stable for the coming edge
    always @(negedge clk) begin
        if (!reset && pop && pndng) begin
            if (tx_exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL tx_unexpected: act=%h exp=none", D_pop);
            end else begin
                check("tx_d_pop", D_pop, tx_exp_q.pop_front());
            end
        end
        if (!reset && rx_ready && rx_valid) begin
            if (rx_exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL rx_unexpected: act=%h exp=none", rx_data);
            end else begin
                check("rx_data", rx_data, rx_exp_q.pop_front());
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [W-1:0] d, input bit expect_store);
        wr_en = 1'b1; wr_data = d;
        if (expect_store) tx_exp_q.push_back(d);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_pop(input int n);
        pop = 1'b1;
        repeat (n) tick();
        pop = 1'b0;
    endtask

    task automatic do_push(input logic [W-1:0] d, input bit expect_store);
        push = 1'b1; D_push = d;
        if (expect_store) rx_exp_q.push_back(d);
        tick();
        push = 1'b0;
    endtask

    task automatic do_consume(input int n);
        rx_ready = 1'b1;
        repeat (n) tick();
        rx_ready = 1'b0;
    endtask

    task automatic do_reset();
        check("txq_drained", W'(tx_exp_q.size()), '0);
        check("rxq_drained", W'(rx_exp_q.size()), '0);
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset and ordering
        reset = 1'b1;
        repeat (5) tick();
        check("rst_full", W'(full), '0);
        check("rst_pndng", W'(pndng), '0);
        check("rst_rx_valid", W'(rx_valid), '0);
        check("rst_d_pop", D_pop, '0);
        check("rst_rx_data", rx_data, '0);
        check("rst_ovf", W'(tx_ovf_cnt), '0);
        check("rst_drop", W'(rx_drop_cnt), '0);
        reset = 1'b0;
        do_write(32'h01000001, 1'b1);
        check("pndng_latency", W'(pndng), 32'd1);
        do_write(32'h01000002, 1'b1);
        do_write(32'h01000003, 1'b1);
        do_pop(3);
        check("pndng_after_3_pops", W'(pndng), '0);

        // TX fill, overflow, write+pop while full
        do_reset();
        for (int i = 0; i < 7; i++) do_write(32'h10 + W'(i), 1'b1);
        check("full_before_8th", W'(full), '0);
        do_write(32'h17, 1'b1);
        check("full_after_8th", W'(full), 32'd1);
        do_write(32'h18, 1'b0);
        check("ovf_cnt_1", W'(tx_ovf_cnt), 32'd1);
        check("full_after_ovf", W'(full), 32'd1);
        pop = 1'b1;
        do_write(32'hAB, 1'b1);
        pop = 1'b0;
        check("full_after_wr_pop", W'(full), 32'd1);
        check("ovf_after_wr_pop", W'(tx_ovf_cnt), 32'd1);
        do_pop(8);
        check("pndng_drained", W'(pndng), '0);
        do_pop(2);
        check("pop_empty_ignored", W'(pndng), '0);

        // RX filter
        do_reset();
        do_push(32'h02AAAAAA, 1'b1);
        check("rx_valid_latency", W'(rx_valid), 32'd1);
        do_push(32'hFFBBBBBB, 1'b1);
        do_push(32'h03CCCCCC, 1'b0);
        check("rx_drop_filter", W'(rx_drop_cnt), 32'd1);
        do_consume(2);
        check("rx_valid_drained", W'(rx_valid), '0);
        do_consume(1);
        check("rx_ready_empty_ignored", W'(rx_valid), '0);

        // RX full, then push+consume while full
        do_reset();
        for (int i = 0; i < 8; i++) do_push(32'h02000000 + W'(i), 1'b1);
        do_push(32'h02000008, 1'b0);
        check("rx_drop_full", W'(rx_drop_cnt), 32'd1);
        rx_ready = 1'b1;
        do_push(32'h020000FF, 1'b1);
        rx_ready = 1'b0;
        check("rx_drop_after_push_pop", W'(rx_drop_cnt), 32'd1);
        check("rx_valid_after_push_pop", W'(rx_valid), 32'd1);
        do_consume(8);
        check("rx_valid_drained2", W'(rx_valid), '0);

        // Wrap-around: 20 write-then-pop rounds
        do_reset();
        for (int i = 0; i < 20; i++) begin
            do_write(32'h05000000 + W'(i * 3), 1'b1);
            check("wrap_pndng_set", W'(pndng), 32'd1);
            do_pop(1);
            check("wrap_pndng_clr", W'(pndng), '0);
        end

        // Reset mid-operation with concurrent write and push
        do_reset();
        for (int i = 0; i < 8; i++) do_write(32'h07000000 + W'(i), 1'b1);
        do_write(32'h07000008, 1'b0);
        do_pop(4);
        for (int i = 0; i < 3; i++) do_push(32'h02000100 + W'(i), 1'b1);
        do_push(32'h09000000, 1'b0);
        check("mid_pndng_pre", W'(pndng), 32'd1);
        check("mid_rx_valid_pre", W'(rx_valid), 32'd1);
        check("mid_ovf_pre", W'(tx_ovf_cnt), 32'd1);
        check("mid_drop_pre", W'(rx_drop_cnt), 32'd1);
        reset = 1'b1; wr_en = 1'b1; wr_data = 32'h0BAD0001;
        push = 1'b1; D_push = 32'h02BAD002;
        tick();
        wr_en = 1'b0; push = 1'b0;
        check("mid_pndng", W'(pndng), '0);
        check("mid_rx_valid", W'(rx_valid), '0);
        check("mid_ovf", W'(tx_ovf_cnt), '0);
        check("mid_drop", W'(rx_drop_cnt), '0);
        check("mid_d_pop", D_pop, '0);
        check("mid_rx_data", rx_data, '0);
        reset = 1'b0;
        tx_exp_q.delete();
        rx_exp_q.delete();
        tick();
        check("post_pndng", W'(pndng), '0);
        check("post_rx_valid", W'(rx_valid), '0);
        do_write(32'h06000001, 1'b1);
        do_pop(1);
        do_push(32'h02000777, 1'b1);
        do_consume(1);

        // Final report
        tick();
        check("txq_final", W'(tx_exp_q.size()), '0);
        check("rxq_final", W'(rx_exp_q.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
